// File: rtl/uart_apb_master.sv
// uart_apb_master: single-outstanding APB requester for the UART register port.
// Commands enter on a valid/ready channel; each result is held in a one-entry response register.
module uart_apb_master #(
  parameter int AWIDTH         = 8,
  parameter int DWIDTH         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_wr_i,
  input  logic [AWIDTH-1:0] req_addr_i,
  input  logic [DWIDTH-1:0] req_wdata_i,
  input  logic [3:0]        req_strb_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DWIDTH-1:0] rsp_rdata_o,
  output logic              rsp_err_o,
  output logic              rsp_timeout_o,
  output logic [AWIDTH-1:0] apb_addr_o,
  output logic              apb_sel_o,
  output logic              apb_en_o,
  output logic              apb_wr_o,
  output logic [DWIDTH-1:0] apb_wdata_o,
  output logic [3:0]        apb_strb_o,
  input  logic [DWIDTH-1:0] apb_rdata_i,
  input  logic              apb_ready_i,
  input  logic              apb_err_i
);

  localparam int CW_RAW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CW     = (CW_RAW > 8) ? CW_RAW : 8;
  // Expiry is detected on the last allowed ACCESS cycle, so compare against TIMEOUT_CYCLES-1.
  localparam logic [CW-1:0] WAIT_LAST = (TIMEOUT_CYCLES == 0) ? '0 : CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t        state, state_next;
  logic [CW-1:0] wait_cnt;
  logic          accept, done, expire;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Handshake outputs decode straight from the state so reset drops sel/en asynchronously.
  always_comb begin
    state_next  = state;
    accept      = 1'b0;
    done        = 1'b0;
    expire      = 1'b0;
    req_ready_o = 1'b0;
    rsp_valid_o = 1'b0;
    apb_sel_o   = 1'b0;
    apb_en_o    = 1'b0;
    case (state)
      IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          accept     = 1'b1;
          state_next = SETUP;
        end
      end
      SETUP: begin
        apb_sel_o  = 1'b1;
        state_next = ACCESS;
      end
      ACCESS: begin
        apb_sel_o = 1'b1;
        apb_en_o  = 1'b1;
        if (apb_ready_i) begin
          done       = 1'b1;
          state_next = RESP;
        end else if ((TIMEOUT_CYCLES != 0) && (wait_cnt == WAIT_LAST)) begin
          expire     = 1'b1;
          state_next = RESP;
        end
      end
      RESP: begin
        rsp_valid_o = 1'b1;
        if (rsp_ready_i) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      apb_addr_o    <= '0;
      apb_wr_o      <= 1'b0;
      apb_wdata_o   <= '0;
      apb_strb_o    <= '0;
      wait_cnt      <= '0;
      rsp_rdata_o   <= '0;
      rsp_err_o     <= 1'b0;
      rsp_timeout_o <= 1'b0;
    end else begin
      if (accept) begin
        apb_addr_o  <= req_addr_i;
        apb_wr_o    <= req_wr_i;
        apb_wdata_o <= req_wr_i ? req_wdata_i : '0;
        apb_strb_o  <= req_wr_i ? req_strb_i : 4'h0;
      end
      if (state == SETUP)
        wait_cnt <= '0;
      else if ((state == ACCESS) && !apb_ready_i)
        wait_cnt <= wait_cnt + 1'b1;
      // A ready slave on the expiry cycle completes normally; done takes priority.
      if (done) begin
        rsp_rdata_o   <= apb_wr_o ? '0 : apb_rdata_i;
        rsp_err_o     <= apb_err_i;
        rsp_timeout_o <= 1'b0;
      end else if (expire) begin
        rsp_rdata_o   <= '0;
        rsp_err_o     <= 1'b1;
        rsp_timeout_o <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_apb_master.sv
// tb_uart_apb_master: table-driven checks of uart_apb_master with a response scoreboard queue.
// The bench plays the APB slave and the response consumer itself.
module tb_uart_apb_master;

  localparam int AW = 8;
  localparam int TO = 8;
  localparam logic [7:0] NEVER = 8'hFF;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid, req_ready, req_wr;
  logic [AW-1:0] req_addr;
  logic [31:0]   req_wdata;
  logic [3:0]    req_strb;
  logic          rsp_valid, rsp_ready, rsp_err, rsp_timeout;
  logic [31:0]   rsp_rdata;
  logic [AW-1:0] apb_addr;
  logic          apb_sel, apb_en, apb_wr, apb_ready, apb_err;
  logic [31:0]   apb_wdata, apb_rdata;
  logic [3:0]    apb_strb;

  always #5 clk = ~clk;

  uart_apb_master #(.AWIDTH(AW), .DWIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_wr_i(req_wr),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_strb_i(req_strb),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
    .rsp_err_o(rsp_err), .rsp_timeout_o(rsp_timeout),
    .apb_addr_o(apb_addr), .apb_sel_o(apb_sel), .apb_en_o(apb_en), .apb_wr_o(apb_wr),
    .apb_wdata_o(apb_wdata), .apb_strb_o(apb_strb), .apb_rdata_i(apb_rdata),
    .apb_ready_i(apb_ready), .apb_err_i(apb_err)
  );

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
    logic [3:0]    strb;
    logic [7:0]    waits;
    logic [31:0]   slv_rdata;
    logic          slv_err;
    logic [31:0]   exp_wdata;
    logic [3:0]    exp_strb;
    int            exp_access;
    logic [31:0]   exp_rdata;
    logic          exp_err;
    logic          exp_to;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        to;
  } rsp_t;

  rsp_t exp_q[$];
  vec_t vecs[7];
  int   checks   = 0;
  int   failures = 0;

  task automatic compare(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Drives one command, plays the slave through SETUP/ACCESS and leaves the bench at a RESP negedge.
  task automatic applyStimulus(input vec_t v);
    int n;
    @(negedge clk);
    req_valid = 1'b1;
    req_wr    = v.wr;
    req_addr  = v.addr;
    req_wdata = v.wdata;
    req_strb  = v.strb;
    apb_ready = 1'b0;
    apb_err   = 1'b0;
    apb_rdata = 32'h0;
    compare("req_ready_idle", 96'(req_ready), 96'(1'b1));
    @(posedge clk);
    exp_q.push_back('{rdata: v.exp_rdata, err: v.exp_err, to: v.exp_to});
    #1 req_valid = 1'b0;
    @(negedge clk);
    compare("setup_ctrl", 96'({apb_sel, apb_en, req_ready, rsp_valid}), 96'(4'b1000));
    compare("setup_bus", 96'({apb_addr, apb_wr, apb_wdata, apb_strb}),
            96'({v.addr, v.wr, v.exp_wdata, v.exp_strb}));
    n = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (!(apb_sel && apb_en)) break;
      n++;
      compare("access_bus", 96'({apb_addr, apb_wr, apb_wdata, apb_strb, req_ready}),
              96'({v.addr, v.wr, v.exp_wdata, v.exp_strb, 1'b0}));
      apb_ready = (v.waits != NEVER) && (c == int'(v.waits));
      apb_rdata = v.slv_rdata;
      apb_err   = apb_ready ? v.slv_err : 1'b0;
    end
    apb_ready = 1'b0;
    apb_err   = 1'b0;
    compare("access_cycles", 96'(n), 96'(v.exp_access));
    compare("resp_entry", 96'({apb_sel, apb_en, rsp_valid, req_ready}), 96'(4'b0010));
  endtask

  // Holds rsp_ready low for 'hold' cycles, then handshakes and compares against the scoreboard.
  task automatic checkOutput(input int hold);
    rsp_t        e;
    logic [33:0] snap;
    int          waited;
    waited = 0;
    while (!rsp_valid && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!rsp_valid) begin
      compare("rsp_valid_wait", 96'(rsp_valid), 96'(1'b1));
      return;
    end
    snap = {rsp_rdata, rsp_err, rsp_timeout};
    for (int i = 0; i < hold; i++) begin
      compare("resp_hold", 96'({rsp_valid, req_ready, apb_sel, rsp_rdata, rsp_err, rsp_timeout}),
              96'({3'b100, snap}));
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    if (exp_q.size() == 0) begin
      compare("scoreboard_empty", 96'(0), 96'(1));
    end else begin
      e = exp_q.pop_front();
      compare("rsp_rdata", 96'(rsp_rdata), 96'(e.rdata));
      compare("rsp_err", 96'(rsp_err), 96'(e.err));
      compare("rsp_timeout", 96'(rsp_timeout), 96'(e.to));
    end
    compare("req_ready_in_resp", 96'({req_ready, rsp_valid}), 96'(2'b01));
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    compare("resp_release", 96'({rsp_valid, req_ready}), 96'(2'b01));
  endtask

  initial begin
    // Stimulus table: inputs, slave behaviour and expected results.
    vecs[0] = '{wr: 1'b1, addr: 8'h04, wdata: 32'h0000_00A5, strb: 4'hF, waits: 8'd0,
                slv_rdata: 32'hFFFF_0000, slv_err: 1'b0, exp_wdata: 32'h0000_00A5, exp_strb: 4'hF,
                exp_access: 1, exp_rdata: 32'h0, exp_err: 1'b0, exp_to: 1'b0};
    vecs[1] = '{wr: 1'b0, addr: 8'h10, wdata: 32'hCAFE_BABE, strb: 4'hF, waits: 8'd3,
                slv_rdata: 32'h1234_5678, slv_err: 1'b0, exp_wdata: 32'h0, exp_strb: 4'h0,
                exp_access: 4, exp_rdata: 32'h1234_5678, exp_err: 1'b0, exp_to: 1'b0};
    vecs[2] = '{wr: 1'b1, addr: 8'h08, wdata: 32'h0000_5A5A, strb: 4'h3, waits: 8'd1,
                slv_rdata: 32'h7777_7777, slv_err: 1'b1, exp_wdata: 32'h0000_5A5A, exp_strb: 4'h3,
                exp_access: 2, exp_rdata: 32'h0, exp_err: 1'b1, exp_to: 1'b0};
    vecs[3] = '{wr: 1'b0, addr: 8'h0C, wdata: 32'h1111_1111, strb: 4'h1, waits: 8'd0,
                slv_rdata: 32'h0BAD_F00D, slv_err: 1'b0, exp_wdata: 32'h0, exp_strb: 4'h0,
                exp_access: 1, exp_rdata: 32'h0BAD_F00D, exp_err: 1'b0, exp_to: 1'b0};
    vecs[4] = '{wr: 1'b0, addr: 8'h20, wdata: 32'h0, strb: 4'h0, waits: NEVER,
                slv_rdata: 32'hDEAD_BEEF, slv_err: 1'b1, exp_wdata: 32'h0, exp_strb: 4'h0,
                exp_access: 8, exp_rdata: 32'h0, exp_err: 1'b1, exp_to: 1'b1};
    vecs[5] = '{wr: 1'b1, addr: 8'hFC, wdata: 32'h8000_0001, strb: 4'h5, waits: 8'd7,
                slv_rdata: 32'h5555_5555, slv_err: 1'b0, exp_wdata: 32'h8000_0001, exp_strb: 4'h5,
                exp_access: 8, exp_rdata: 32'h0, exp_err: 1'b0, exp_to: 1'b0};
    vecs[6] = '{wr: 1'b0, addr: 8'h3C, wdata: 32'h0, strb: 4'hF, waits: 8'd8,
                slv_rdata: 32'hA5A5_A5A5, slv_err: 1'b0, exp_wdata: 32'h0, exp_strb: 4'h0,
                exp_access: 8, exp_rdata: 32'h0, exp_err: 1'b1, exp_to: 1'b1};

    rst       = 1'b1;
    req_valid = 1'b0;
    req_wr    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_strb  = '0;
    rsp_ready = 1'b0;
    apb_rdata = '0;
    apb_ready = 1'b0;
    apb_err   = 1'b0;
    #1;
    compare("reset_rsp", 96'({req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout}),
            96'({1'b1, 1'b0, 32'h0, 1'b0, 1'b0}));
    compare("reset_apb", 96'({apb_addr, apb_sel, apb_en, apb_wr, apb_wdata, apb_strb}), 96'(0));
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i]);
      checkOutput(i % 3);
    end

    // Back-to-back: the second command waits while the first response is stalled.
    applyStimulus(vecs[1]);
    req_valid = 1'b1;
    req_wr    = vecs[0].wr;
    req_addr  = vecs[0].addr;
    req_wdata = vecs[0].wdata;
    req_strb  = vecs[0].strb;
    checkOutput(5);
    applyStimulus(vecs[0]);
    checkOutput(0);

    // Reset asserted in the middle of ACCESS drops the transfer with no response.
    @(negedge clk);
    req_valid = 1'b1;
    req_wr    = 1'b0;
    req_addr  = 8'h30;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (3) @(negedge clk);
    compare("pre_reset_access", 96'({apb_sel, apb_en}), 96'(2'b11));
    #2 rst = 1'b1;
    #1 compare("reset_async", 96'({apb_sel, apb_en, rsp_valid, req_ready}), 96'(4'b0001));
    @(negedge clk);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      compare("post_reset_idle", 96'({rsp_valid, req_ready, apb_sel}), 96'(3'b010));
    end
    applyStimulus(vecs[3]);
    checkOutput(1);

    compare("scoreboard_drained", 96'(exp_q.size()), 96'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout actual=running required=finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule
